// File: rtl/rn_jesus_pkg.sv
// Shared constants and the maximal-length Galois mask table for rn_jesus.
package rn_jesus_pkg;

  localparam logic [31:0] DEFAULT_SEED = 32'h0000_ACE1;
  localparam logic [31:0] DEFAULT_TAPS = 32'h0000_B400;

  // Bit (t-1) is set for each tap t of a known maximal-length polynomial.
  function automatic logic [31:0] max_taps(input int width);
    logic [31:0] mask;
    mask = 32'h0;
    case (width)
      3:  mask = 32'h0000_0006;
      4:  mask = 32'h0000_000C;
      5:  mask = 32'h0000_0014;
      6:  mask = 32'h0000_0030;
      7:  mask = 32'h0000_0060;
      8:  mask = 32'h0000_00B8;
      9:  mask = 32'h0000_0110;
      10: mask = 32'h0000_0240;
      11: mask = 32'h0000_0500;
      12: mask = 32'h0000_0829;
      13: mask = 32'h0000_100D;
      14: mask = 32'h0000_2015;
      15: mask = 32'h0000_6000;
      16: mask = DEFAULT_TAPS;
      17: mask = 32'h0001_2000;
      18: mask = 32'h0002_0400;
      19: mask = 32'h0004_0023;
      20: mask = 32'h0009_0000;
      21: mask = 32'h0014_0000;
      22: mask = 32'h0030_0000;
      23: mask = 32'h0042_0000;
      24: mask = 32'h00E1_0000;
      25: mask = 32'h0120_0000;
      26: mask = 32'h0200_0023;
      27: mask = 32'h0400_0013;
      28: mask = 32'h0900_0000;
      29: mask = 32'h1400_0000;
      30: mask = 32'h2000_0029;
      31: mask = 32'h4800_0000;
      32: mask = 32'h8020_0003;
      default: mask = 32'h0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/rn_jesus_lfsr_galois_step.sv
// Combinational one-step advance of a right-shifting Galois LFSR.
module lfsr_galois_step
  import rn_jesus_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS)
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next
);

  // The bit shifted out of the LSB is fed back into every tap position.
  always_comb begin
    next = (state >> 1) ^ (state[0] ? TAPS : '0);
  end

endmodule

// File: rtl/rn_jesus.sv
// Pseudo-random bit source: maximal-length Galois LFSR, one step per enabled clock.
// Optional zero-state recovery is built when RN_JESUS_LOCKUP_GUARD_EN is defined.
module rn_jesus
  import rn_jesus_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED),
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(max_taps(WIDTH))
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_rand
);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] step_next;
  logic [WIDTH-1:0] next_state;

  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "rn_jesus: WIDTH=%0d outside 3..32", WIDTH);
  end else if (TAPS[WIDTH-1] == 1'b0) begin : g_bad_taps
    $fatal(1, "rn_jesus: TAPS top bit must be set");
  end

`ifdef RN_JESUS_LOCKUP_GUARD_EN
  if (SEED == '0) begin : g_zero_seed
    $warning("rn_jesus: SEED is zero, lockup guard will recover");
  end
`else
  if (SEED == '0) begin : g_zero_seed
    $fatal(1, "rn_jesus: SEED must be nonzero");
  end
`endif

  lfsr_galois_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_step (
    .state (state),
    .next  (step_next)
  );

`ifdef RN_JESUS_LOCKUP_GUARD_EN
  // All-zero is a fixed point of the shift; kick it back onto the cycle.
  always_comb begin
    next_state = (state == '0) ? WIDTH'(1) : step_next;
  end
`else
  always_comb begin
    next_state = step_next;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else if (i_en) begin
      state <= next_state;
    end
  end

  assign o_rand = state[0];

endmodule

// File: tb/tb_rn_jesus.sv
// Scoreboard bench for rn_jesus: directed scenarios plus randomized enable/reset traffic.
module tb_rn_jesus;

  localparam int          W    = 16;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] TAPS = 16'hB400;

  logic clk;
  logic rst;
  logic i_en;
  logic o_rand;

  int checks;
  int failures;

  logic [15:0] exp_q[$];
  logic [15:0] m_state;

  rn_jesus dut (
    .clk    (clk),
    .rst    (rst),
    .i_en   (i_en),
    .o_rand (o_rand)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: polynomial rule from the register description, with the optional zero kick.
  function automatic logic [15:0] model_step(input logic [15:0] s);
`ifdef RN_JESUS_LOCKUP_GUARD_EN
    if (s == 16'h0) return 16'h0001;
`endif
    return (s >> 1) ^ (s[0] ? TAPS : 16'h0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One clock: drive at the falling edge, advance the model at the rising edge.
  task automatic cycle(input logic r, input logic e);
    @(negedge clk);
    rst  = r;
    i_en = e;
    @(posedge clk);
    if (r) m_state = SEED;
    else if (e) m_state = model_step(m_state);
    exp_q.push_back(m_state);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      checks++;
      if (dut.state !== e || o_rand !== e[0]) begin
        failures++;
        $display("FAIL scoreboard state=%h rand=%b required state=%h rand=%b",
                 dut.state, o_rand, e, e[0]);
      end
    end
  end

  logic [15:0] first_steps [5] = '{16'hE270, 16'h7138, 16'h389C, 16'h1C4E, 16'h0E27};
  logic        first_bits  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int ones;
    int first_ret;
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    i_en     = 1'b0;
    m_state  = SEED;

    // Reset then hold with enable low.
    cycle(1'b1, 1'b0);
    check("reset_rand", {31'h0, o_rand}, 32'h1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0);
    check("reset_hold_state", {16'h0, dut.state}, {16'h0, SEED});

    // Known first steps after reset.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1);
      check("first_step_state", {16'h0, dut.state}, {16'h0, first_steps[i]});
      check("first_step_rand", {31'h0, o_rand}, {31'h0, first_bits[i]});
    end

    // Enable pattern 1,0,0,1 advances exactly two steps.
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    check("hold_two_steps", {16'h0, dut.state},
          {16'h0, model_step(model_step(first_steps[4]))});

    // Full period from reset.
    cycle(1'b1, 1'b0);
    ones = 0;
    first_ret = 0;
    for (int i = 1; i <= 65535; i++) begin
      cycle(1'b0, 1'b1);
      if (o_rand === 1'b1) ones++;
      if (first_ret == 0 && dut.state === SEED) first_ret = i;
    end
    check("period_length", first_ret, 65535);
    check("period_ones", ones, 32768);

    // Reset mid-run restarts the same sequence.
    for (int i = 0; i < 1000; i++) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    check("midrun_reset_state", {16'h0, dut.state}, {16'h0, SEED});
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1);
      check("midrun_restart", {16'h0, dut.state}, {16'h0, first_steps[i]});
    end

    // Randomized enable with occasional reset.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1);
    end

    // Zero state: stuck without the guard, recovers to 1 with it.
    @(negedge clk);
    i_en = 1'b0;
    rst  = 1'b0;
    #1;
    force dut.state = 16'h0;
    #1;
    release dut.state;
    m_state = 16'h0;
    cycle(1'b0, 1'b1);
`ifdef RN_JESUS_LOCKUP_GUARD_EN
    check("lockup_recover", {16'h0, dut.state}, 32'h1);
`else
    check("lockup_stuck", {16'h0, dut.state}, 32'h0);
`endif
    cycle(1'b0, 1'b1);

    @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
